// File: rtl/key_ctrl.sv
// key_ctrl: front-panel key conditioner for the up/down display counter.
// Two raw push-buttons are polarity-corrected, synchronised, debounced and
// turned into level controls: direction (1 = up) and run (1 = counting).
// Optional macro KEY_LONG_CLR_EN: holding the run key for LONG_CYCLES emits
// a one-cycle clr pulse, and run then toggles on release of a short press only.
// Without the macro clr is tied 0 and run toggles on the press event.
module key_ctrl #(
    parameter int DEB_CYCLES     = 20000,
    parameter int LONG_CYCLES    = 2000000,
    parameter int KEY_ACTIVE_LOW = 1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       key_dir,
    input  logic       key_run,
    output logic       direction,
    output logic       run,
    output logic [1:0] key_state,
    output logic       clr
);

    localparam int CW = $clog2(DEB_CYCLES + 1);
    localparam logic [CW-1:0] CNT_ONE = CW'(1);
    localparam logic [CW-1:0] DEB_MAX = CW'(DEB_CYCLES);

    typedef enum logic [1:0] {
        RELEASED,
        PRESS_WAIT,
        PRESSED,
        RELEASE_WAIT
    } deb_state_e;

    // Bit 0 is the dir key, bit 1 the run key; 1 always means "pressed".
    logic [1:0]    raw_pressed;
    logic [1:0]    sync1_q;
    logic [1:0]    sync2_q;
    deb_state_e    state_q [2];
    logic [CW-1:0] cnt_q   [2];
    logic [CW-1:0] cnt_inc [2];
    logic [1:0]    key_state_q;
    logic [1:0]    press_evt;
    logic [1:0]    rel_evt;
    logic          direction_q;
    logic          run_q;

    assign raw_pressed = (KEY_ACTIVE_LOW != 0) ? ~{key_run, key_dir} : {key_run, key_dir};

    // Two-flop synchroniser; resets to "released" so a held key must re-debounce.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            sync1_q <= 2'b00;
            sync2_q <= 2'b00;
        end else begin
            sync1_q <= raw_pressed;
            sync2_q <= sync1_q;
        end
    end

    // Accept strobes: fire on the edge where the stable count reaches DEB_CYCLES.
    always_comb begin
        press_evt = 2'b00;
        rel_evt   = 2'b00;
        for (int k = 0; k < 2; k++) begin
            cnt_inc[k] = cnt_q[k] + CNT_ONE;
            case (state_q[k])
                RELEASED:     press_evt[k] = sync2_q[k] && (CNT_ONE >= DEB_MAX);
                PRESS_WAIT:   press_evt[k] = sync2_q[k] && (cnt_inc[k] >= DEB_MAX);
                PRESSED:      rel_evt[k]   = !sync2_q[k] && (CNT_ONE >= DEB_MAX);
                RELEASE_WAIT: rel_evt[k]   = !sync2_q[k] && (cnt_inc[k] >= DEB_MAX);
                default:      ;
            endcase
        end
    end

    // Per-key debounce FSM; counter returns to 0 on bounce or on acceptance.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int k = 0; k < 2; k++) begin
                state_q[k] <= RELEASED;
                cnt_q[k]   <= '0;
            end
            key_state_q <= 2'b00;
        end else begin
            for (int k = 0; k < 2; k++) begin
                case (state_q[k])
                    RELEASED: begin
                        if (press_evt[k]) begin
                            state_q[k] <= PRESSED;
                            cnt_q[k]   <= '0;
                        end else if (sync2_q[k]) begin
                            state_q[k] <= PRESS_WAIT;
                            cnt_q[k]   <= CNT_ONE;
                        end
                    end
                    PRESS_WAIT: begin
                        if (!sync2_q[k]) begin
                            state_q[k] <= RELEASED;
                            cnt_q[k]   <= '0;
                        end else if (press_evt[k]) begin
                            state_q[k] <= PRESSED;
                            cnt_q[k]   <= '0;
                        end else begin
                            cnt_q[k]   <= cnt_inc[k];
                        end
                    end
                    PRESSED: begin
                        if (rel_evt[k]) begin
                            state_q[k] <= RELEASED;
                            cnt_q[k]   <= '0;
                        end else if (!sync2_q[k]) begin
                            state_q[k] <= RELEASE_WAIT;
                            cnt_q[k]   <= CNT_ONE;
                        end
                    end
                    RELEASE_WAIT: begin
                        if (sync2_q[k]) begin
                            state_q[k] <= PRESSED;
                            cnt_q[k]   <= '0;
                        end else if (rel_evt[k]) begin
                            state_q[k] <= RELEASED;
                            cnt_q[k]   <= '0;
                        end else begin
                            cnt_q[k]   <= cnt_inc[k];
                        end
                    end
                    default: begin
                        state_q[k] <= RELEASED;
                        cnt_q[k]   <= '0;
                    end
                endcase
            end
            key_state_q <= (key_state_q | press_evt) & ~rel_evt;
        end
    end

`ifdef KEY_LONG_CLR_EN
    localparam int HW = $clog2(LONG_CYCLES + 1);
    localparam logic [HW-1:0] LONG_MAX = HW'(LONG_CYCLES);

    logic [HW-1:0] hold_q;
    logic [HW-1:0] hold_inc;
    logic          clr_q;
    logic          holding;

    assign hold_inc = hold_q + HW'(1);
    assign holding  = key_state_q[1] && !rel_evt[1];

    // Run-key hold timer: restarts on press, saturates at LONG_CYCLES, fires clr once.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            hold_q <= '0;
            clr_q  <= 1'b0;
        end else begin
            clr_q <= 1'b0;
            if (press_evt[1]) begin
                hold_q <= '0;
            end else if (holding && (hold_q != LONG_MAX)) begin
                hold_q <= hold_inc;
                clr_q  <= (hold_inc == LONG_MAX);
            end
        end
    end

    // Direction toggles on dir press; run toggles on release of a short hold only.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            direction_q <= 1'b1;
            run_q       <= 1'b1;
        end else begin
            if (press_evt[0]) direction_q <= ~direction_q;
            if (rel_evt[1] && (hold_q < LONG_MAX)) run_q <= ~run_q;
        end
    end

    assign clr = clr_q;
`else
    // Direction and run each toggle on their key's press event.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            direction_q <= 1'b1;
            run_q       <= 1'b1;
        end else begin
            if (press_evt[0]) direction_q <= ~direction_q;
            if (press_evt[1]) run_q       <= ~run_q;
        end
    end

    assign clr = 1'b0;
`endif

    assign direction = direction_q;
    assign run       = run_q;
    assign key_state = key_state_q;

endmodule

// File: tb/tb_key_ctrl.sv
// Directed bench for key_ctrl with DEB_CYCLES=4, LONG_CYCLES=16, active-low keys.
// Expected values are hand-derived: a raw edge is accepted 2+4 = 6 edges later.
// Build with +define+KEY_LONG_CLR_EN to exercise the long-press clear variant.
module tb_key_ctrl;

    logic       clk;
    logic       rst;
    logic       key_dir;
    logic       key_run;
    logic       direction;
    logic       run;
    logic [1:0] key_state;
    logic       clr;

    int checks = 0;
    int errors = 0;

    key_ctrl #(
        .DEB_CYCLES    (4),
        .LONG_CYCLES   (16),
        .KEY_ACTIVE_LOW(1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .key_dir  (key_dir),
        .key_run  (key_run),
        .direction(direction),
        .run      (run),
        .key_state(key_state),
        .clr      (clr)
    );

    // Clock: 10 ns period, rising edges at 5, 15, 25 ...
    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Advance n rising edges and settle 1 ns past the last one.
    task automatic step(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    initial begin
        rst     = 1'b1;
        key_dir = 1'b1;
        key_run = 1'b1;
        #2;
        check("rst_dir", direction, 1);
        check("rst_run", run, 1);
        check("rst_ks", key_state, 0);
        check("rst_clr", clr, 0);
        step(2);
        rst = 1'b0;
        step(2);

        // Clean press on the dir key, long hold, release, re-press.
        key_dir = 1'b0;
        step(5);
        check("t1_ks_early", key_state, 0);
        check("t1_dir_early", direction, 1);
        step(1);
        check("t1_ks_on", key_state, 2'b01);
        check("t1_dir_tog", direction, 0);
        step(14);
        check("t1_no_repeat", direction, 0);
        key_dir = 1'b1;
        step(5);
        check("t1_ks_held", key_state, 2'b01);
        step(1);
        check("t1_ks_off", key_state, 0);
        check("t1_rel_noeff", direction, 0);
        key_dir = 1'b0;
        step(6);
        check("t1_repress", direction, 1);
        key_dir = 1'b1;
        step(8);
        check("t1_ks_final", key_state, 0);

        // Bounce: 3 low, 1 high, 3 low, then released; nothing accepted.
        key_dir = 1'b0;
        step(3);
        key_dir = 1'b1;
        step(1);
        key_dir = 1'b0;
        step(3);
        key_dir = 1'b1;
        for (int i = 0; i < 10; i++) begin
            step(1);
            check("t2_bounce_ks", key_state, 0);
            check("t2_bounce_dir", direction, 1);
        end

        // Both keys pressed in the same cycle.
        key_dir = 1'b0;
        key_run = 1'b0;
        step(5);
        check("t3_dir_early", direction, 1);
        check("t3_run_early", run, 1);
        step(1);
        check("t3_ks", key_state, 2'b11);
        check("t3_dir", direction, 0);
`ifdef KEY_LONG_CLR_EN
        check("t3_run", run, 1);
`else
        check("t3_run", run, 0);
`endif
        key_dir = 1'b1;
        key_run = 1'b1;
        step(6);
        check("t3_ks_rel", key_state, 0);
        check("t3_run_rel", run, 0);
        step(2);

        // Reset asserted mid-debounce, key kept held.
        key_run = 1'b0;
        step(2);
        rst = 1'b1;
        #1;
        check("t4_async_dir", direction, 1);
        check("t4_async_run", run, 1);
        check("t4_async_ks", key_state, 0);
        check("t4_async_clr", clr, 0);
        step(2);
        rst = 1'b0;
        step(5);
        check("t4_ks_early", key_state, 0);
        check("t4_run_early", run, 1);
        step(1);
        check("t4_ks", key_state, 2'b10);
`ifdef KEY_LONG_CLR_EN
        check("t4_run", run, 1);
`else
        check("t4_run", run, 0);
`endif
        key_run = 1'b1;
        step(6);
        check("t4_ks_rel", key_state, 0);
        check("t4_run_rel", run, 0);
        step(2);

        // Run key held 30 cycles.
        key_run = 1'b0;
        step(6);
        check("t5_ks", key_state, 2'b10);
`ifdef KEY_LONG_CLR_EN
        check("t5_run_press", run, 0);
`else
        check("t5_run_press", run, 1);
`endif
        step(15);
        check("t5_clr_before", clr, 0);
        step(1);
`ifdef KEY_LONG_CLR_EN
        check("t5_clr_pulse", clr, 1);
`else
        check("t5_clr_pulse", clr, 0);
`endif
        step(1);
        check("t5_clr_after", clr, 0);
        step(7);
        key_run = 1'b1;
        step(6);
        check("t5_ks_rel", key_state, 0);
        check("t5_clr_rel", clr, 0);
`ifdef KEY_LONG_CLR_EN
        check("t5_run_rel", run, 0);
`else
        check("t5_run_rel", run, 1);
`endif
        step(2);

        // Run key held 8 cycles: short press.
        key_run = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t6_clr_hold", clr, 0);
        end
        check("t6_run_held", run, 0);
        key_run = 1'b1;
        step(5);
        check("t6_run_early", run, 0);
        step(1);
        check("t6_ks_rel", key_state, 0);
`ifdef KEY_LONG_CLR_EN
        check("t6_run_rel", run, 1);
`else
        check("t6_run_rel", run, 0);
`endif
        check("t6_clr_rel", clr, 0);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/key_ctrl.md
Name: key_ctrl

Overview:
- Front-panel key conditioner; sits directly upstream of the two-digit up/down display counter.
- Synchronises and debounces two raw push-buttons and turns presses into level controls: direction (up/down) and run (count/pause).
- The counter's direction input is driven from this block's direction output.
- run and clr are made available for gating and clearing the counter's 1 Hz tick.

Parameters:
- DEB_CYCLES, 20000: consecutive stable cycles needed to accept a key change (20 ms at 1 MHz clk).
- LONG_CYCLES, 2000000: hold time in cycles for a long press (2 s at 1 MHz); used only with the optional feature.
- KEY_ACTIVE_LOW, 1: 1 means the raw keys read 0 when pressed; 0 means they read 1 when pressed.

Ports:
- clk  input  1  system clock (1 MHz board clock)
- rst  input  1  asynchronous, active-high reset
- key_dir  input  1  raw direction button, asynchronous to clk
- key_run  input  1  raw run/pause button, asynchronous to clk
- direction  output  1  1 = count up, 0 = count down; level, registered
- run  output  1  1 = counting enabled, 0 = paused; level, registered
- key_state  output  2  debounced pressed levels; bit0 = dir key, bit1 = run key; 1 = pressed
- clr  output  1  one-cycle clear pulse to the counter; tied 0 unless the optional feature is compiled in

Behaviour:
- Interface: one clock; reset is asynchronous and active-high (clk, rst).
- Reset values: direction=1, run=1, key_state=2'b00, clr=0. All synchronisers read "released". All debounce and hold counters are 0.
- Reset is honoured mid-debounce and mid-hold. Any partial count is discarded. A key still held when rst deasserts must be stable for DEB_CYCLES before it is accepted as pressed.
- Input path, per key:
  - Apply polarity from KEY_ACTIVE_LOW.
  - Pass through a 2-flop synchroniser.
  - Feed a per-key debounce FSM.
- Debounce FSM states (per key):
  - RELEASED: synced=pressed -> PRESS_WAIT, counter=1.
  - PRESS_WAIT: synced=released -> RELEASED, counter=0 (bounce). Otherwise counter+1. When counter reaches DEB_CYCLES -> PRESSED and key_state bit set.
  - PRESSED: synced=released -> RELEASE_WAIT, counter=1.
  - RELEASE_WAIT: synced=pressed -> PRESSED, counter=0. Otherwise count the same way. When counter reaches DEB_CYCLES -> RELEASED and key_state bit cleared.
- Counter width is clog2(DEB_CYCLES+1) bits. The counter never wraps.
- Latency: a clean raw edge changes key_state exactly 2+DEB_CYCLES clk edges later.
- Press/release events are single-cycle internal strobes, asserted on the edge where key_state changes.
- Dir key: direction toggles on the edge where the press event fires. Release has no effect.
- Run key (feature off): run toggles on the press event.
- Both keys accepted on the same edge: both outputs update on that edge, independently.
- Holding a key gives exactly one toggle. There is no auto-repeat.
- Bounces shorter than DEB_CYCLES produce no event and no output change.

Optional Feature:
- Macro: KEY_LONG_CLR_EN.
- Defined:
  - A hold counter for the run key starts at the press event and saturates at LONG_CYCLES.
  - When the hold counter reaches LONG_CYCLES while still pressed, clr pulses high for exactly one cycle. It fires once per hold.
  - run toggles on the release event only if the hold was shorter than LONG_CYCLES. A long press leaves run unchanged.
  - Reset clears the hold counter.
- Not defined:
  - clr is constant 0 and no hold counter is built.
  - run toggles on the press event as described in Behaviour.

Test Plan (DEB_CYCLES=4, LONG_CYCLES=16, KEY_ACTIVE_LOW=1):
- Reset: rst pulsed asynchronously between clk edges -> direction=1, run=1, key_state=00, clr=0 immediately, without waiting for a clk edge.
- Clean press: key_dir driven 1->0 and held 20 cycles -> key_state[0]=1 and direction=0 exactly 6 edges after the drive. Release and re-press -> direction=1.
- Bounce: key_dir low 3 cycles, high 1 cycle, low 3 cycles, then high -> no change to key_state or direction.
- Simultaneous: key_dir and key_run pressed on the same cycle -> direction and run both toggle on the same edge, 6 edges later.
- Reset mid-debounce: key_run low, rst pulsed 2 cycles after the press, key held -> run=1 after reset, then toggles to 0 exactly 6 edges after rst deasserts.
- KEY_LONG_CLR_EN:
  - Hold key_run 30 cycles -> clr high for exactly 1 cycle, 16 edges after the press event; run unchanged after release.
  - Hold 8 cycles -> no clr; run toggles at the release event.
